// File: rtl/mem_access_seq.sv
// mem_access_seq
// Memory access sequencer placed after the bank address logic. It classifies
// a 16-bit physical address as erasable, fixed or invalid. It then runs a
// read, write or read-modify-write increment against a single-port
// synchronous memory. Writes to the editing registers (0x0010-0x0013) are
// transformed before they are stored.
//
// Ports:
//   clk, reset                  - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         - request handshake; accept when both are high
//   req_op[1:0]                 - 00 read, 01 write, 10 increment, 11 reserved
//   req_addr[15:0], req_wdata   - request address and write data (latched at accept)
//   resp_valid                  - one-cycle response pulse
//   resp_rdata[15:0]            - read data, stored write value or incremented value
//   resp_error                  - rejected request (qualifies resp_valid)
//   mem_en, mem_we              - memory strobe and write enable
//   mem_addr, mem_wdata         - memory address and write data (hold between strobes)
//   mem_rdata[15:0]             - memory read data, valid the cycle after a read strobe
module mem_access_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP,
    S_ERR
  } state_e;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  state_e      state_q, state_d;
  logic        inc_q, inc_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        addr_fixed;
  logic        addr_invalid;
  logic        req_err;
  logic [15:0] edited_wdata;
  op_e         op;

  assign op           = op_e'(req_op);
  assign accept       = req_valid && req_ready_q;
  assign addr_invalid = (req_addr >= 16'hA000);
  assign addr_fixed   = (req_addr >= 16'h0800) && !addr_invalid;
  assign req_err      = (op == OP_RSVD) || addr_invalid ||
                        (addr_fixed && (op != OP_READ));

  // Editing-register transforms. These apply to writes only.
  always_comb begin
    edited_wdata = req_wdata;
    case (req_addr)
      16'h0010: edited_wdata = {req_wdata[0], req_wdata[15:1]};   // CYR
      16'h0011: edited_wdata = {req_wdata[15], req_wdata[15:1]};  // SR
      16'h0012: edited_wdata = {req_wdata[14:0], req_wdata[15]};  // CYL
      16'h0013: edited_wdata = {7'd0, req_wdata[15:7]};           // EDOP
      default:  edited_wdata = req_wdata;
    endcase
  end

  // Outputs are registered. Each one is loaded on the edge that enters the
  // state in which it must be visible.
  always_comb begin
    state_d      = state_q;
    inc_d        = inc_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d      = S_ERR;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
          end else if (op == OP_WRITE) begin
            state_d     = S_WR;
            inc_d       = 1'b0;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_addr;
            mem_wdata_d = edited_wdata;
          end else begin
            state_d    = S_RD;
            inc_d      = (op == OP_INC);
            mem_en_d   = 1'b1;
            mem_addr_d = req_addr;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (inc_q) begin
          // Write back to the same address, which mem_addr_q still holds.
          state_d     = S_WR;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = mem_rdata + 16'd1;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = mem_rdata;
        end
      end
      S_WR: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_wdata_q;
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      inc_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      inc_q        <= inc_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_error;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] tb_mem [0:65535];

  int tests = 0;
  int fails = 0;

  // Per-cycle record of outputs after an accept (index = cycle number).
  logic        r_en  [1:6];
  logic        r_we  [1:6];
  logic        r_rv  [1:6];
  logic        r_re  [1:6];
  logic        r_rdy [1:6];
  logic [15:0] r_addr[1:6];
  logic [15:0] r_wd  [1:6];
  logic [15:0] r_rd  [1:6];

  mem_access_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory: read data appears the cycle after a read strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata        <= tb_mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd);
    int unsigned wait_n;
    @(negedge clk);
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    wait_n    = 0;
    while (req_ready !== 1'b1 && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 20) begin
      chk("accept_timeout", 32'(wait_n), 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the request fields so the DUT has to use its latched copies.
    req_valid = 1'b0;
    req_op    = 2'b11;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hDEAD;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      r_en[k]   = mem_en;
      r_we[k]   = mem_we;
      r_rv[k]   = resp_valid;
      r_re[k]   = resp_error;
      r_rdy[k]  = req_ready;
      r_addr[k] = mem_addr;
      r_wd[k]   = mem_wdata;
      r_rd[k]   = resp_rdata;
    end
  endtask

  logic [15:0] ed_addr [4];
  logic [15:0] ed_in   [4];
  logic [15:0] ed_exp  [4];
  logic [1:0]  er_op   [4];
  logic [15:0] er_addr [4];
  int          acc_cyc [3];

  initial begin
    int    n_acc;
    int    cyc;
    logic  any_en;
    logic  seen_bad;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) tb_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",  32'(req_ready), 32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rerror", 32'(resp_error), 32'd0);
    chk("rst_rdata",  32'(resp_rdata), 32'd0);
    chk("rst_en",     32'(mem_en), 32'd0);
    chk("rst_we",     32'(mem_we), 32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_wdata",  32'(mem_wdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    // Write 0x1234 to 0x0300
    run_req(2'b01, 16'h0300, 16'h1234);
    chk("wr_c1_en",    32'(r_en[1]), 32'd1);
    chk("wr_c1_we",    32'(r_we[1]), 32'd1);
    chk("wr_c1_addr",  32'(r_addr[1]), 32'h0300);
    chk("wr_c1_wdata", 32'(r_wd[1]), 32'h1234);
    chk("wr_c1_rv",    32'(r_rv[1]), 32'd0);
    chk("wr_c1_rdy",   32'(r_rdy[1]), 32'd0);
    chk("wr_c2_rv",    32'(r_rv[2]), 32'd1);
    chk("wr_c2_re",    32'(r_re[2]), 32'd0);
    chk("wr_c2_rdata", 32'(r_rd[2]), 32'h1234);
    chk("wr_c2_en",    32'(r_en[2]), 32'd0);
    chk("wr_c3_rv",    32'(r_rv[3]), 32'd0);
    chk("wr_c3_rdy",   32'(r_rdy[3]), 32'd1);
    chk("wr_mem",      32'(tb_mem[16'h0300]), 32'h1234);

    // Read back 0x0300
    run_req(2'b00, 16'h0300, 16'h0000);
    chk("rd_c1_en",    32'(r_en[1]), 32'd1);
    chk("rd_c1_we",    32'(r_we[1]), 32'd0);
    chk("rd_c1_addr",  32'(r_addr[1]), 32'h0300);
    chk("rd_c2_en",    32'(r_en[2]), 32'd0);
    chk("rd_c2_rv",    32'(r_rv[2]), 32'd0);
    chk("rd_c3_rv",    32'(r_rv[3]), 32'd1);
    chk("rd_c3_re",    32'(r_re[3]), 32'd0);
    chk("rd_c3_rdata", 32'(r_rd[3]), 32'h1234);
    chk("rd_c3_rdy",   32'(r_rdy[3]), 32'd0);
    chk("rd_c4_rdy",   32'(r_rdy[4]), 32'd1);
    chk("rd_c4_rv",    32'(r_rv[4]), 32'd0);

    // Editing registers
    ed_addr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    ed_in   = '{16'h8001, 16'h8001, 16'h8001, 16'hFF80};
    ed_exp  = '{16'hC000, 16'hC000, 16'h0003, 16'h01FF};
    for (int i = 0; i < 4; i++) begin
      run_req(2'b01, ed_addr[i], ed_in[i]);
      chk($sformatf("edit%0d_wdata", i), 32'(r_wd[1]), 32'(ed_exp[i]));
      chk($sformatf("edit%0d_resp", i),  32'(r_rd[2]), 32'(ed_exp[i]));
      run_req(2'b00, ed_addr[i], 16'h0000);
      chk($sformatf("edit%0d_read", i),  32'(r_rd[3]), 32'(ed_exp[i]));
    end

    // Increment 0x00FF -> 0x0100
    tb_mem[16'h0100] = 16'h00FF;
    run_req(2'b10, 16'h0100, 16'h0000);
    chk("inc_c1_en",    32'(r_en[1]), 32'd1);
    chk("inc_c1_we",    32'(r_we[1]), 32'd0);
    chk("inc_c2_en",    32'(r_en[2]), 32'd0);
    chk("inc_c3_en",    32'(r_en[3]), 32'd1);
    chk("inc_c3_we",    32'(r_we[3]), 32'd1);
    chk("inc_c3_addr",  32'(r_addr[3]), 32'h0100);
    chk("inc_c3_wdata", 32'(r_wd[3]), 32'h0100);
    chk("inc_c3_rv",    32'(r_rv[3]), 32'd0);
    chk("inc_c4_rv",    32'(r_rv[4]), 32'd1);
    chk("inc_c4_rdata", 32'(r_rd[4]), 32'h0100);
    chk("inc_c5_rdy",   32'(r_rdy[5]), 32'd1);
    chk("inc_mem",      32'(tb_mem[16'h0100]), 32'h0100);

    // Increment wraps 0xFFFF -> 0x0000
    tb_mem[16'h0100] = 16'hFFFF;
    run_req(2'b10, 16'h0100, 16'h0000);
    chk("incw_c3_wdata", 32'(r_wd[3]), 32'h0000);
    chk("incw_c4_rv",    32'(r_rv[4]), 32'd1);
    chk("incw_c4_rdata", 32'(r_rd[4]), 32'h0000);
    chk("incw_mem",      32'(tb_mem[16'h0100]), 32'h0000);

    // Read from a fixed address succeeds
    tb_mem[16'h8400] = 16'hBEEF;
    run_req(2'b00, 16'h8400, 16'h0000);
    chk("fix_c3_rv",    32'(r_rv[3]), 32'd1);
    chk("fix_c3_re",    32'(r_re[3]), 32'd0);
    chk("fix_c3_rdata", 32'(r_rd[3]), 32'hBEEF);

    // Error requests
    er_op   = '{2'b01, 2'b10, 2'b00, 2'b11};
    er_addr = '{16'h0800, 16'h8400, 16'hA000, 16'h0300};
    for (int i = 0; i < 4; i++) begin
      run_req(er_op[i], er_addr[i], 16'h5555);
      any_en = 1'b0;
      for (int k = 1; k <= 6; k++) any_en = any_en | r_en[k];
      chk($sformatf("err%0d_rv", i),    32'(r_rv[1]), 32'd1);
      chk($sformatf("err%0d_re", i),    32'(r_re[1]), 32'd1);
      chk($sformatf("err%0d_rdata", i), 32'(r_rd[1]), 32'd0);
      chk($sformatf("err%0d_no_en", i), 32'(any_en), 32'd0);
      chk($sformatf("err%0d_c2_rv", i), 32'(r_rv[2]), 32'd0);
      chk($sformatf("err%0d_c2_rdy", i), 32'(r_rdy[2]), 32'd1);
    end
    chk("err_fixed_intact", 32'(tb_mem[16'h0800]), 32'd0);

    // Three queued reads with req_valid held high
    @(negedge clk);
    req_op    = 2'b00;
    req_addr  = 16'h0300;
    req_valid = 1'b1;
    n_acc     = 0;
    cyc       = 0;
    while (n_acc < 3 && cyc < 40) begin
      if (req_ready === 1'b1) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk);
      #1;
      if (n_acc == 3) req_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    chk("queue_count", 32'(n_acc), 32'd3);
    if (n_acc == 3) begin
      chk("queue_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
      chk("queue_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    end
    repeat (6) @(negedge clk);

    // Reset during cycle 2 of an increment
    tb_mem[16'h0100] = 16'h0042;
    seen_bad = 1'b0;
    @(negedge clk);
    req_op    = 2'b10;
    req_addr  = 16'h0100;
    req_valid = 1'b1;
    chk("rstmid_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_c1_en", 32'(mem_en), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_en",    32'(mem_en), 32'd0);
    chk("rstmid_we",    32'(mem_we), 32'd0);
    chk("rstmid_rv",    32'(resp_valid), 32'd0);
    chk("rstmid_rdy0",  32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_rdy1",  32'(req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (mem_we === 1'b1 || resp_valid === 1'b1) seen_bad = 1'b1;
      @(negedge clk);
    end
    chk("rstmid_quiet", 32'(seen_bad), 32'd0);
    chk("rstmid_mem",   32'(tb_mem[16'h0100]), 32'h0042);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
# mem_access_seq

Memory access sequencer sitting directly downstream of the bank address logic. It takes a 16-bit physical address plus an operation, classifies the address as erasable, fixed or invalid, and drives a single-port synchronous memory. Supported operations are read, write and read-modify-write increment. Writes to the editing-register locations are transformed on the way in.

## Interface
- Parameters: none; all widths fixed at 16 bits.
- `clk` in 1 — the single clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — sequencer can accept a request.
- `req_op` in 2 — 00 read, 01 write, 10 increment, 11 reserved.
- `req_addr` in 16 — physical address from the bank address logic.
- `req_wdata` in 16 — write data; ignored for other ops.
- `resp_valid` out 1 — one-cycle response pulse; no backpressure.
- `resp_rdata` out 16 — read data, or post-increment value.
- `resp_error` out 1 — qualifies `resp_valid`; the request was rejected.
- `mem_en` out 1 — memory cycle enable.
- `mem_we` out 1 — write strobe, valid with `mem_en`.
- `mem_addr` out 16 — memory address.
- `mem_wdata` out 16 — memory write data.
- `mem_rdata` in 16 — read data, valid the cycle after a read `mem_en`.

## Operation
- Address classes:
  - erasable: 0x0000–0x07FF;
  - fixed: 0x0800–0x9FFF (fixed-fixed plus banks up to 39 with superbank);
  - invalid: 0xA000 and above.
- Error conditions; each returns `resp_error`=1, `resp_rdata`=0 and performs no memory access:
  - `req_op`=11;
  - any access to an invalid address;
  - write or increment to a fixed address.
- Editing registers apply to write only. The stored value is computed from `req_wdata`:
  - 0x0010 CYR: rotate right by 1;
  - 0x0011 SR: arithmetic shift right by 1;
  - 0x0012 CYL: rotate left by 1;
  - 0x0013 EDOP: logical shift right by 7.
- Read and increment at those addresses are plain, with no edit.
- Increment: new value = `mem_rdata` + 1, modulo 2^16 (0xFFFF -> 0x0000). It is written back to the same address and returned in `resp_rdata`.
- Write response: `resp_rdata` = the value actually stored (edited if applicable).
- State machine:
  - IDLE -> ERR on accept of an error request.
  - IDLE -> RD on accept of a read or increment.
  - IDLE -> WR on accept of a write.
  - RD -> CAP.
  - CAP -> RESP for a read; CAP -> WR for an increment.
  - WR -> RESP.
  - ERR -> IDLE, asserting the error response in that cycle.
  - RESP -> IDLE, with `resp_valid` high in RESP.
- `req_ready` = 1 only in IDLE. A request is accepted on a clock edge with `req_valid` and `req_ready` both high. Request fields are latched at accept and need not be held afterwards.

## Timing
- Cycle 0 is the accept cycle. All outputs are registered.
- Read:
  - cycle 1: `mem_en`=1, `mem_we`=0;
  - cycle 2: `mem_rdata` captured;
  - cycle 3: `resp_valid`. Latency 3.
- Write: `mem_en`=`mem_we`=1 in cycle 1; `resp_valid` in cycle 2. Latency 2.
- Increment:
  - read strobe in cycle 1;
  - capture in cycle 2;
  - write strobe in cycle 3 with `mem_addr` unchanged;
  - `resp_valid` in cycle 4.
- Error: `resp_valid` with `resp_error` in cycle 1; `mem_en` stays 0 throughout.
- `req_ready` returns high in the cycle after the response cycle, so back-to-back accepts are spaced by latency + 1.
- Outside strobe cycles: `mem_en`, `mem_we` = 0. `mem_addr`, `mem_wdata` hold their last values.
- Reset values: state IDLE; `req_ready`=1 from the first cycle after reset. These outputs are 0:
  - `resp_valid`, `resp_error`, `resp_rdata`;
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`.
- While `reset` is high, `req_ready`=0 and no request is accepted.
- Reset mid-operation:
  - the operation is abandoned and no response is issued;
  - `mem_en` and `mem_we` are 0 in the cycle after the reset edge;
  - a pending increment write-back never occurs.

## Test plan
- Write 0x1234 to 0x0300, then read 0x0300:
  - write: `mem_we` in cycle 1, `resp_valid` in cycle 2, `resp_rdata`=0x1234;
  - read: `resp_valid` in cycle 3, `resp_rdata`=0x1234.
- Editing registers, each followed by a read of the same address:
  - write 0x8001 to 0x0010 -> 0xC000 stored and returned;
  - write 0x8001 to 0x0011 -> 0xC000;
  - write 0x8001 to 0x0012 -> 0x0003;
  - write 0xFF80 to 0x0013 -> 0x01FF.
- Increment 0x0100 holding 0x00FF -> write-back 0x0100 in cycle 3, `resp_rdata`=0x0100 in cycle 4.
- Increment 0x0100 holding 0xFFFF -> write-back and response 0x0000.
- Errors, each giving `resp_error`=1 in cycle 1 with `mem_en` never asserted:
  - write to 0x0800;
  - increment at 0x8400;
  - read 0xA000;
  - `req_op`=11.
- Read 0x8400 -> normal response, no error.
- Hold `req_valid` high with three queued reads -> accepts spaced exactly 4 cycles apart.
- Reset at cycle 2 of an increment -> no write strobe, no `resp_valid`; `req_ready`=1 in the cycle after reset deasserts.
